// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 16-bit WISC pipeline. Owns the PC, drives the
//   instruction memory address, and loads the IF/ID pipeline register. Handles
//   redirects from ID, hazard stalls, memory-miss bubbles and HLT.
//
// Ports
//   clk           in   1   clock, rising edge
//   rst           in   1   synchronous active-high reset
//   stall         in   1   hold PC, IF/ID, state and miss counter
//   branch_taken  in   1   redirect fetch to branch_target (overrides stall)
//   branch_target in  16   redirect address
//   imem_addr     out 16   fetch address (current PC)
//   imem_data     in  16   instruction word at imem_addr
//   imem_valid    in   1   imem_data valid this cycle (0 = miss, retry)
//   if_id_instr   out 16   registered instruction to ID
//   if_id_pc      out 16   registered address of if_id_instr
//   if_id_valid   out  1   1 = real instruction, 0 = bubble
//   halted        out  1   fetch frozen on HLT
//   miss_cycles   out 16   saturating count of cycles spent in MISS
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] miss_cycles
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_MISS  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ipc_q, ipc_d;
  logic        vld_q, vld_d;
  logic [15:0] miss_q, miss_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // State register: every piece of stage state updates here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ipc_q   <= 16'h0000;
      vld_q   <= 1'b0;
      miss_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state logic. A bubble clears valid and the instruction word; the
  // IF/ID PC is left as-is since nothing downstream consumes it without valid.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    miss_d  = miss_q;

    if (branch_taken) begin
      // Redirect wins over stall and abandons any pending miss or wrong-path HLT
      pc_d    = branch_target;
      instr_d = NOP_INSTR;
      vld_d   = 1'b0;
      state_d = S_FETCH;
    end else if (!stall) begin
      unique case (state_q)
        S_FETCH, S_MISS: begin
          if (state_q == S_MISS) begin
            miss_d = sat_inc16(miss_q);
          end
          if (imem_valid) begin
            instr_d = imem_data;
            ipc_d   = pc_q;
            vld_d   = 1'b1;
            if (imem_data[15:12] == HLT_OPCODE) begin
              state_d = S_HALT;
            end else begin
              pc_d    = pc_q + 16'd2;
              state_d = S_FETCH;
            end
          end else begin
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
            state_d = S_MISS;
          end
        end
        S_HALT: begin
          // HLT was already delivered once; keep feeding bubbles
          instr_d = NOP_INSTR;
          vld_d   = 1'b0;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    imem_addr   = pc_q;
    if_id_instr = instr_q;
    if_id_pc    = ipc_q;
    if_id_valid = vld_q;
    halted      = (state_q == S_HALT);
    miss_cycles = miss_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] miss_cycles;

  int n_checks;
  int n_pass;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .imem_valid   (imem_valid),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .miss_cycles  (miss_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] data;
    logic        dv;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic        e_v;
    logic        e_h;
    logic [15:0] e_m;
  } vec_t;

  localparam int NV = 27;
  vec_t vt[NV];

  function automatic vec_t mk(input logic r, input logic s, input logic b,
                              input logic [15:0] t, input logic [15:0] d, input logic dv,
                              input logic [15:0] ea, input logic [15:0] ei, input logic [15:0] ep,
                              input logic ev, input logic eh, input logic [15:0] em);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.data = d; v.dv = dv;
    v.e_addr = ea; v.e_instr = ei; v.e_pc = ep; v.e_v = ev; v.e_h = eh; v.e_m = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t,
                      input logic [15:0] d, input logic dv);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    imem_data = d; imem_valid = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ea, input logic [15:0] ei,
                         input logic [15:0] ep, input logic ev, input logic eh,
                         input logic [15:0] em);
    chk({tag, ".addr"},  imem_addr,           ea);
    chk({tag, ".instr"}, if_id_instr,         ei);
    chk({tag, ".pc"},    if_id_pc,            ep);
    chk({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, ev});
    chk({tag, ".halt"},  {15'd0, halted},      {15'd0, eh});
    chk({tag, ".miss"},  miss_cycles,         em);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
    imem_data = 16'h0; imem_valid = 1'b0;

    //              rst  stl  br   tgt       data      dv    addr      instr     pc        v    h    miss
    vt[0]  = mk(1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0, 16'h0000,16'h0000,16'h0000,1'b0,1'b0,16'd0);
    vt[1]  = mk(1'b0,1'b0,1'b0,16'h0000,16'h1111,1'b1, 16'h0002,16'h1111,16'h0000,1'b1,1'b0,16'd0);
    vt[2]  = mk(1'b0,1'b0,1'b0,16'h0000,16'h2222,1'b1, 16'h0004,16'h2222,16'h0002,1'b1,1'b0,16'd0);
    vt[3]  = mk(1'b0,1'b0,1'b0,16'h0000,16'h3333,1'b1, 16'h0006,16'h3333,16'h0004,1'b1,1'b0,16'd0);
    vt[4]  = mk(1'b0,1'b0,1'b0,16'h0000,16'h4444,1'b1, 16'h0008,16'h4444,16'h0006,1'b1,1'b0,16'd0);
    // redirect to 0x0004, then three misses and a hit
    vt[5]  = mk(1'b0,1'b0,1'b1,16'h0004,16'h0000,1'b0, 16'h0004,16'h0000,16'h0006,1'b0,1'b0,16'd0);
    vt[6]  = mk(1'b0,1'b0,1'b0,16'h0000,16'hDEAD,1'b0, 16'h0004,16'h0000,16'h0006,1'b0,1'b0,16'd0);
    vt[7]  = mk(1'b0,1'b0,1'b0,16'h0000,16'hDEAD,1'b0, 16'h0004,16'h0000,16'h0006,1'b0,1'b0,16'd1);
    vt[8]  = mk(1'b0,1'b0,1'b0,16'h0000,16'hDEAD,1'b0, 16'h0004,16'h0000,16'h0006,1'b0,1'b0,16'd2);
    vt[9]  = mk(1'b0,1'b0,1'b0,16'h0000,16'h5555,1'b1, 16'h0006,16'h5555,16'h0004,1'b1,1'b0,16'd3);
    // stall + branch together: branch wins
    vt[10] = mk(1'b0,1'b1,1'b1,16'h0100,16'h7777,1'b1, 16'h0100,16'h0000,16'h0004,1'b0,1'b0,16'd3);
    vt[11] = mk(1'b0,1'b0,1'b0,16'h0000,16'h8888,1'b1, 16'h0102,16'h8888,16'h0100,1'b1,1'b0,16'd3);
    vt[12] = mk(1'b0,1'b1,1'b0,16'h0000,16'h9999,1'b1, 16'h0102,16'h8888,16'h0100,1'b1,1'b0,16'd3);
    vt[13] = mk(1'b0,1'b1,1'b0,16'h0000,16'h9999,1'b1, 16'h0102,16'h8888,16'h0100,1'b1,1'b0,16'd3);
    // HLT at 0x0010, then release by branch to 0x0020
    vt[14] = mk(1'b0,1'b0,1'b1,16'h0010,16'h0000,1'b0, 16'h0010,16'h0000,16'h0100,1'b0,1'b0,16'd3);
    vt[15] = mk(1'b0,1'b0,1'b0,16'h0000,16'hF000,1'b1, 16'h0010,16'hF000,16'h0010,1'b1,1'b1,16'd3);
    vt[16] = mk(1'b0,1'b0,1'b0,16'h0000,16'h1234,1'b1, 16'h0010,16'h0000,16'h0010,1'b0,1'b1,16'd3);
    vt[17] = mk(1'b0,1'b0,1'b0,16'h0000,16'h1234,1'b1, 16'h0010,16'h0000,16'h0010,1'b0,1'b1,16'd3);
    vt[18] = mk(1'b0,1'b0,1'b1,16'h0020,16'h1234,1'b1, 16'h0020,16'h0000,16'h0010,1'b0,1'b0,16'd3);
    vt[19] = mk(1'b0,1'b0,1'b0,16'h0000,16'hABCD,1'b1, 16'h0022,16'hABCD,16'h0020,1'b1,1'b0,16'd3);
    // wrap at 0xFFFE
    vt[20] = mk(1'b0,1'b0,1'b1,16'hFFFE,16'h0000,1'b0, 16'hFFFE,16'h0000,16'h0020,1'b0,1'b0,16'd3);
    vt[21] = mk(1'b0,1'b0,1'b0,16'h0000,16'h1357,1'b1, 16'h0000,16'h1357,16'hFFFE,1'b1,1'b0,16'd3);
    // build miss_cycles up to 5, then reset mid-miss
    vt[22] = mk(1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0, 16'h0000,16'h0000,16'hFFFE,1'b0,1'b0,16'd3);
    vt[23] = mk(1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0, 16'h0000,16'h0000,16'hFFFE,1'b0,1'b0,16'd4);
    vt[24] = mk(1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0, 16'h0000,16'h0000,16'hFFFE,1'b0,1'b0,16'd5);
    vt[25] = mk(1'b1,1'b0,1'b0,16'h0000,16'h2468,1'b1, 16'h0000,16'h0000,16'h0000,1'b0,1'b0,16'd0);
    vt[26] = mk(1'b0,1'b0,1'b0,16'h0000,16'h2468,1'b1, 16'h0002,16'h2468,16'h0000,1'b1,1'b0,16'd0);

    for (int i = 0; i < NV; i++) begin
      step(vt[i].rst, vt[i].stall, vt[i].br, vt[i].tgt, vt[i].data, vt[i].dv);
      chk_all($sformatf("v%0d", i), vt[i].e_addr, vt[i].e_instr, vt[i].e_pc,
              vt[i].e_v, vt[i].e_h, vt[i].e_m);
    end

    // Stall during MISS freezes the counter; HLT captured from MISS halts.
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk_all("mh0", 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk_all("mh1", 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk_all("mh2", 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd1);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'hF00D, 1'b1);
    chk_all("mh3", 16'h0002, 16'hF00D, 16'h0002, 1'b1, 1'b1, 16'd2);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'hF00D, 1'b1);
    chk_all("mh4", 16'h0002, 16'h0000, 16'h0002, 1'b0, 1'b1, 16'd2);
    // Stall while halted holds everything
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h1111, 1'b1);
    chk_all("mh5", 16'h0002, 16'h0000, 16'h0002, 1'b0, 1'b1, 16'd2);

    // Reset beats a simultaneous branch
    step(1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000, 1'b0);
    chk_all("rb0", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0ACE, 1'b1);
    chk_all("rb1", 16'h0002, 16'h0ACE, 16'h0000, 1'b1, 1'b0, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
